// File: rtl/coeff_apply.sv
// Qualifies a new coefficient word after STABLE_CYCLES consecutive edges, then applies it on the next frame strobe.
// Minimum latency STABLE_CYCLES+1 edges; no backpressure, a changed input while pending discards the qualified value.
module coeff_apply #(
  parameter int NB            = 8,
  parameter int STABLE_CYCLES = 3
) (
  input  logic          i_clock,
  input  logic          i_reset,
  input  logic [NB-1:0] i_coeffs,
  input  logic          i_frame_start,
  input  logic          i_enable,
  output logic [NB-1:0] o_coeffs,
  output logic          o_update,
  output logic          o_pending,
  output logic          o_discard
);

  typedef enum logic [1:0] {IDLE, QUALIFY, PENDING} state_t;

  localparam logic [4:0] CNT_MAX = 5'(STABLE_CYCLES);

  state_t        state, state_nxt;
  logic [NB-1:0] cand, cand_nxt;
  logic [NB-1:0] coeffs_nxt;
  logic [4:0]    cnt, cnt_nxt, cnt_inc;
  logic          update_nxt, discard_nxt;
  logic          in_diff_applied, in_diff_cand, qualified;

  assign in_diff_applied = (i_coeffs != o_coeffs);
  assign in_diff_cand    = (i_coeffs != cand);
  assign cnt_inc         = (cnt >= CNT_MAX) ? CNT_MAX : cnt + 5'd1;
  assign qualified       = !in_diff_cand && (cnt_inc == CNT_MAX);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state     <= IDLE;
      cand      <= '0;
      cnt       <= '0;
      o_coeffs  <= '0;
      o_update  <= 1'b0;
      o_discard <= 1'b0;
    end else begin
      state     <= state_nxt;
      cand      <= cand_nxt;
      cnt       <= cnt_nxt;
      o_coeffs  <= coeffs_nxt;
      o_update  <= update_nxt;
      o_discard <= discard_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (!i_enable) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (in_diff_applied) state_nxt = QUALIFY;
        // A value that settles back onto the applied word needs no frame.
        QUALIFY: if (qualified) state_nxt = (cand != o_coeffs) ? PENDING : IDLE;
        PENDING: begin
          if (i_frame_start)     state_nxt = IDLE;
          else if (in_diff_cand) state_nxt = QUALIFY;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    cand_nxt    = cand;
    cnt_nxt     = cnt;
    coeffs_nxt  = o_coeffs;
    update_nxt  = 1'b0;
    discard_nxt = 1'b0;
    if (!i_enable) begin
      cnt_nxt = '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_diff_applied) begin
            cand_nxt = i_coeffs;
            cnt_nxt  = 5'd1;
          end
        end
        QUALIFY: begin
          if (in_diff_cand) begin
            cand_nxt = i_coeffs;
            cnt_nxt  = 5'd1;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
        PENDING: begin
          // The frame strobe wins; a simultaneous input change is seen from IDLE next edge.
          if (i_frame_start) begin
            coeffs_nxt = cand;
            update_nxt = 1'b1;
          end else if (in_diff_cand) begin
            discard_nxt = 1'b1;
            cand_nxt    = i_coeffs;
            cnt_nxt     = 5'd1;
          end
        end
        default: cnt_nxt = '0;
      endcase
    end
  end

  assign o_pending = (state == PENDING);

endmodule
